// File: rtl/obstacle_spawner.sv
// Obstacle spawner: spawns ground obstacles on game ticks, scrolls them left,
// retires them at the left edge and answers registered per-pixel hit queries.
module obstacle_spawner #(
  parameter int         NUM_SLOTS      = 4,
  parameter logic [9:0] OBS_WIDTH      = 10'd20,
  parameter logic [9:0] SPEED          = 10'd4,
  parameter logic [7:0] SPAWN_INTERVAL = 8'd64,
  parameter logic [9:0] SPAWN_X        = 10'd620,
  parameter logic [9:0] SCREEN_H       = 10'd480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        game_en,
  input  logic        freeze,
  input  logic        clear,
  input  logic [9:0]  random_in,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  output logic        obstacle_pixel,
  output logic [2:0]  active_count,
  output logic [15:0] passed_count,
  output logic        spawn_miss
);

  logic [NUM_SLOTS-1:0] valid_q, valid_d;
  logic [9:0]           x_q [NUM_SLOTS];
  logic [9:0]           x_d [NUM_SLOTS];
  logic [9:0]           h_q [NUM_SLOTS];
  logic [9:0]           h_d [NUM_SLOTS];
  logic [7:0]           spawn_cnt_q, spawn_cnt_d;
  logic [15:0]          passed_d;
  logic [2:0]           active_d;
  logic [2:0]           retire_cnt;
  logic [16:0]          passed_sum;
  logic [9:0]           h_clamp;
  logic                 tick, spawn_try, found, miss_d, hit_d;

  assign tick      = game_en & ~freeze & ~clear;
  assign spawn_try = tick && (spawn_cnt_q == SPAWN_INTERVAL - 8'd1);
  assign h_clamp   = (random_in > SCREEN_H) ? SCREEN_H : random_in;

  always_comb begin
    valid_d     = valid_q;
    x_d         = x_q;
    h_d         = h_q;
    spawn_cnt_d = spawn_cnt_q;
    retire_cnt  = '0;
    found       = 1'b0;
    miss_d      = 1'b0;
    if (tick) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (valid_q[i]) begin
          if (x_q[i] < SPEED) begin
            valid_d[i] = 1'b0;
            retire_cnt = retire_cnt + 3'd1;
          end else begin
            x_d[i] = x_q[i] - SPEED;
          end
        end
      end
      spawn_cnt_d = spawn_try ? 8'd0 : spawn_cnt_q + 8'd1;
      // Eligibility uses pre-tick valid, so a slot retiring now stays empty.
      if (spawn_try) begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
          if (!valid_q[i] && !found) begin
            found      = 1'b1;
            valid_d[i] = 1'b1;
            x_d[i]     = SPAWN_X;
            h_d[i]     = h_clamp;
          end
        end
        miss_d = ~found;
      end
    end
  end

  always_comb begin
    passed_sum = {1'b0, passed_count} + {14'd0, retire_cnt};
    passed_d   = passed_sum[16] ? 16'hFFFF : passed_sum[15:0];
    active_d   = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      active_d = active_d + {2'd0, valid_d[i]};
    end
  end

  // Hit test against the state in effect this cycle; widened to avoid x+width wrap.
  always_comb begin
    hit_d = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (valid_q[i] &&
          ({1'b0, pixel_x} >= {1'b0, x_q[i]}) &&
          ({1'b0, pixel_x} <  ({1'b0, x_q[i]} + {1'b0, OBS_WIDTH})) &&
          (pixel_y >= SCREEN_H - h_q[i]) &&
          (pixel_y <  SCREEN_H)) begin
        hit_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q        <= '0;
      spawn_cnt_q    <= '0;
      obstacle_pixel <= 1'b0;
      active_count   <= '0;
      passed_count   <= '0;
      spawn_miss     <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        x_q[i] <= '0;
        h_q[i] <= '0;
      end
    end else if (clear) begin
      valid_q        <= '0;
      spawn_cnt_q    <= '0;
      obstacle_pixel <= 1'b0;
      active_count   <= '0;
      passed_count   <= '0;
      spawn_miss     <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        x_q[i] <= '0;
        h_q[i] <= '0;
      end
    end else begin
      valid_q        <= valid_d;
      spawn_cnt_q    <= spawn_cnt_d;
      obstacle_pixel <= hit_d;
      active_count   <= active_d;
      passed_count   <= passed_d;
      spawn_miss     <= miss_d;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        x_q[i] <= x_d[i];
        h_q[i] <= h_d[i];
      end
    end
  end

endmodule

// File: tb/tb_obstacle_spawner.sv
// Scoreboard bench for obstacle_spawner: two instances (spawn interval 8 and 6)
// driven with identical random stimulus and checked against a slot-list model.
module tb_obstacle_spawner;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        game_en = 1'b0, freeze = 1'b0, clear = 1'b0;
  logic [9:0]  random_in = '0, pixel_x = '0, pixel_y = '0;
  logic        pix0, pix1, miss0, miss1;
  logic [2:0]  act0, act1;
  logic [15:0] pass0, pass1;

  always #5 clk = ~clk;

  obstacle_spawner #(.SPAWN_INTERVAL(8'd8)) u0 (
    .clk(clk), .rst(rst), .game_en(game_en), .freeze(freeze), .clear(clear),
    .random_in(random_in), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .obstacle_pixel(pix0), .active_count(act0), .passed_count(pass0), .spawn_miss(miss0));

  // Interval 6 divides the 156-tick obstacle lifetime, so retire and spawn coincide.
  obstacle_spawner #(.SPAWN_INTERVAL(8'd6)) u1 (
    .clk(clk), .rst(rst), .game_en(game_en), .freeze(freeze), .clear(clear),
    .random_in(random_in), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .obstacle_pixel(pix1), .active_count(act1), .passed_count(pass1), .spawn_miss(miss1));

  typedef struct {
    bit pix;
    int act;
    int passed;
    bit miss;
  } exp_t;

  exp_t q0[$], q1[$];
  int   n_checks = 0, n_fail = 0;
  int   mv [2][4], mx [2][4], mh [2][4];
  int   mcnt [2], mpass [2];
  int   interval [2] = '{8, 6};

  task automatic chk(string name, int actual, int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic void model_reset();
    for (int u = 0; u < 2; u++) begin
      for (int s = 0; s < 4; s++) begin
        mv[u][s] = 0; mx[u][s] = 0; mh[u][s] = 0;
      end
      mcnt[u] = 0; mpass[u] = 0;
    end
  endfunction

  function automatic exp_t model_step(int u, bit ge, bit fr, bit cl, int rnd, int px, int py);
    exp_t e;
    int   was [4];
    int   free_s;
    e.pix = 0; e.miss = 0; e.act = 0; e.passed = 0;
    for (int s = 0; s < 4; s++)
      if (mv[u][s] != 0 && px >= mx[u][s] && px < mx[u][s] + 20 &&
          py >= 480 - mh[u][s] && py < 480) e.pix = 1;
    if (cl) begin
      for (int s = 0; s < 4; s++) begin mv[u][s] = 0; mx[u][s] = 0; mh[u][s] = 0; end
      mcnt[u] = 0; mpass[u] = 0;
      e.pix = 0;
      return e;
    end
    if (ge && !fr) begin
      for (int s = 0; s < 4; s++) was[s] = mv[u][s];
      for (int s = 0; s < 4; s++) begin
        if (was[s] != 0) begin
          if (mx[u][s] < 4) begin
            mv[u][s] = 0;
            mpass[u] = (mpass[u] < 65535) ? mpass[u] + 1 : 65535;
          end else begin
            mx[u][s] -= 4;
          end
        end
      end
      if (mcnt[u] == interval[u] - 1) begin
        mcnt[u] = 0;
        free_s = -1;
        for (int s = 0; s < 4; s++) if (was[s] == 0 && free_s < 0) free_s = s;
        if (free_s >= 0) begin
          mv[u][free_s] = 1;
          mx[u][free_s] = 620;
          mh[u][free_s] = (rnd > 480) ? 480 : rnd;
        end else begin
          e.miss = 1;
        end
      end else begin
        mcnt[u]++;
      end
    end
    for (int s = 0; s < 4; s++) e.act += mv[u][s];
    e.passed = mpass[u];
    return e;
  endfunction

  task automatic step(bit ge, bit fr, bit cl, int rnd, int px, int py);
    @(negedge clk);
    game_en = ge; freeze = fr; clear = cl;
    random_in = rnd[9:0]; pixel_x = px[9:0]; pixel_y = py[9:0];
    q0.push_back(model_step(0, ge, fr, cl, rnd, px, py));
    q1.push_back(model_step(1, ge, fr, cl, rnd, px, py));
  endtask

  // Pixels aimed around a live obstacle of either instance, including its edges.
  task automatic pick(output int px, output int py);
    int u, s;
    u = $urandom_range(0, 1);
    s = $urandom_range(0, 3);
    if ($urandom_range(0, 3) != 0 && mv[u][s] != 0) begin
      px = mx[u][s] + $urandom_range(0, 24) - 2;
      py = 480 - mh[u][s] - 2 + $urandom_range(0, mh[u][s] + 4);
    end else begin
      px = $urandom_range(0, 1023);
      py = $urandom_range(0, 1023);
    end
    if (px < 0) px = 0;
    if (px > 1023) px = 1023;
    if (py < 0) py = 0;
    if (py > 1023) py = 1023;
  endtask

  function automatic int pick_rnd();
    case ($urandom_range(0, 5))
      0: return 0;
      1: return 480;
      2: return 481;
      3: return 1023;
      default: return $urandom_range(0, 1023);
    endcase
  endfunction

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      chk("u0_obstacle_pixel", int'(pix0), int'(e.pix));
      chk("u0_active_count", int'(act0), e.act);
      chk("u0_passed_count", int'(pass0), e.passed);
      chk("u0_spawn_miss", int'(miss0), int'(e.miss));
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      chk("u1_obstacle_pixel", int'(pix1), int'(e.pix));
      chk("u1_active_count", int'(act1), e.act);
      chk("u1_passed_count", int'(pass1), e.passed);
      chk("u1_spawn_miss", int'(miss1), int'(e.miss));
    end
  end

  task automatic chk_all_zero(string tag);
    chk({tag, "_pix0"}, int'(pix0), 0);
    chk({tag, "_act0"}, int'(act0), 0);
    chk({tag, "_pass0"}, int'(pass0), 0);
    chk({tag, "_miss0"}, int'(miss0), 0);
    chk({tag, "_pix1"}, int'(pix1), 0);
    chk({tag, "_act1"}, int'(act1), 0);
    chk({tag, "_pass1"}, int'(pass1), 0);
    chk({tag, "_miss1"}, int'(miss1), 0);
  endtask

  task automatic random_phase(int n, int fr_pct);
    int px, py;
    for (int i = 0; i < n; i++) begin
      pick(px, py);
      step($urandom_range(0, 2) != 0, $urandom_range(0, 99) < fr_pct, 1'b0, pick_rnd(), px, py);
    end
  endtask

  initial begin
    int px, py;
    model_reset();
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      pick(px, py);
      step(1'b1, 1'b0, 1'b0, 100, px, py);
    end
    step(1'b0, 1'b0, 1'b0, 100, 625, 400);
    step(1'b0, 1'b0, 1'b0, 100, 625, 379);
    step(1'b0, 1'b0, 1'b0, 100, 640, 400);

    for (int i = 0; i < 40; i++) begin
      pick(px, py);
      step(1'b1, 1'b0, 1'b0, pick_rnd(), px, py);
      pick(px, py);
      step(1'b0, 1'b0, 1'b0, pick_rnd(), px, py);
    end

    random_phase(1500, 5);

    for (int i = 0; i < 20; i++) begin
      pick(px, py);
      step(1'b1, 1'b1, 1'b0, pick_rnd(), px, py);
    end

    pick(px, py);
    step(1'b1, 1'b0, 1'b1, pick_rnd(), px, py);
    for (int i = 0; i < 5; i++) begin
      pick(px, py);
      step(1'b0, 1'b0, 1'b0, pick_rnd(), px, py);
    end

    random_phase(400, 5);

    @(negedge clk);
    game_en = 1'b0;
    rst = 1'b0;
    #1;
    chk_all_zero("async_reset");
    model_reset();
    @(negedge clk);
    rst = 1'b1;

    random_phase(300, 5);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", q0.size() + q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/obstacle_spawner.md
Name: obstacle_spawner

Overview:
Downstream consumer of the LFSR random amplitude stage. On each game tick it spawns ground obstacles whose height is taken from random_in and scrolls every active obstacle left at a fixed speed. It retires obstacles that reach the left screen edge and counts them as passed. For the VGA renderer it answers "is this pixel inside an obstacle" with one cycle of latency.

Parameters:
NUM_SLOTS, 4, number of obstacle slots; fixed at 4 for this revision.
OBS_WIDTH, 10'd20, obstacle width in pixels.
SPEED, 10'd4, pixels moved left per game tick; must be at least 1.
SPAWN_INTERVAL, 8'd64, game ticks between spawn attempts; must be at least 1.
SPAWN_X, 10'd620, left-edge x of a newly spawned obstacle.
SCREEN_H, 10'd480, screen height; obstacles sit on row SCREEN_H-1.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset (rst==0 resets)
game_en  in  1  single-cycle game-tick enable
freeze  in  1  game over; holds all motion and spawning
clear  in  1  synchronous new-game clear
random_in  in  10  obstacle height from the random generator, sampled at spawn
pixel_x  in  10  current VGA column
pixel_y  in  10  current VGA row
obstacle_pixel  out  1  registered hit flag for (pixel_x, pixel_y)
active_count  out  3  number of valid slots
passed_count  out  16  number of retired obstacles, saturating
spawn_miss  out  1  one-cycle pulse when a spawn finds no free slot

Behaviour:
- Slot state: valid, x[9:0] (left edge), h[9:0]. Reset (rst low, asynchronous) clears all slots, spawn_cnt, obstacle_pixel, active_count, passed_count and spawn_miss to 0.
- clear (synchronous) has the same effect as reset and takes priority over game_en in the same cycle.
- A tick is game_en && !freeze && !clear. Outside a tick the slots, spawn_cnt and the counters hold, and spawn_miss is 0.
- Move and retire on a tick, for each slot valid before the tick:
  - If x < SPEED: valid<=0 and passed_count increments, saturating at 16'hFFFF.
  - Otherwise: x <= x - SPEED.
  - If several slots retire on the same tick, passed_count adds the number retired, still saturating.
- Spawn counter: spawn_cnt increments on each tick and wraps from SPAWN_INTERVAL-1 to 0. The wrap tick is a spawn attempt.
- Spawn attempt:
  - Picks the lowest-index slot that was invalid before the tick. A slot retiring on the same tick is not eligible.
  - The chosen slot loads valid=1, x=SPAWN_X, h=min(random_in, SCREEN_H).
  - The newly spawned obstacle does not move on its spawn tick.
  - If no slot is free, nothing loads and spawn_miss pulses high for exactly that cycle.
- active_count is registered and always equals the popcount of valid after the update, so it is updated in the same cycle as the slots.
- Pixel hit:
  - A slot hits when valid, x <= pixel_x < x+OBS_WIDTH (11-bit sum, no wrap), and SCREEN_H-h <= pixel_y < SCREEN_H.
  - obstacle_pixel is the OR over all slots, registered with exactly 1 clock of latency. It uses the slot state in effect in the cycle the pixel was presented.
  - Pixel lookup continues while freeze is high.
- h=0 produces no hit rows. random_in values above SCREEN_H clamp to SCREEN_H.
- Reset asserted mid-operation clears everything immediately, with no pending spawn.

Test Plan:
- Parameters: SPAWN_INTERVAL=8, SPEED=4, SPAWN_X=620, OBS_WIDTH=20. Release reset, hold random_in=100, issue 8 game_en pulses -> slot0 valid with x=620, h=100; active_count=1; spawn_miss=0.
- After that spawn, present pixels (625,400), (625,379) and (640,400) -> obstacle_pixel is 1, 0, 0 respectively, each one clock after its pixel is presented.
- Continue ticks -> spawns occur at ticks 16, 24 and 32 with active_count reaching 4. At tick 40 spawn_miss pulses once and active_count stays 4.
- Tick until slot0 reaches x=0; the next tick retires it -> valid=0, passed_count=1. A spawn on that same tick does not reuse slot0.
- Raise freeze for 20 game_en pulses -> x, spawn_cnt and the counters are unchanged, and obstacle_pixel still responds.
- Pulse clear with game_en high in the same cycle -> all slots invalid, active_count=0, passed_count=0. Separately, drop rst mid-run -> all outputs are 0 asynchronously, before the next clock edge.
